multicycle_controller: RTL and testbench

Moore-style FSM that sequences a multi-cycle RV32 datapath with one shared instruction/data memory port. Supports beq, lw, sw, add, sub, and, or, addi, andi, ori. Drives the datapath register-enable and mux selects, and handshakes with memory through mem_req/mem_ready. Illegal instructions and memory timeouts latch a sticky trap.

---
 rtl/multicycle_controller_pkg.sv | 49 ++++
 rtl/multicycle_controller_inst_legal_check.sv | 56 +++++
 rtl/multicycle_controller.sv | 231 +++++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle RV32 controller.
//   state_t  : controller FSM states
//   cause_t  : sticky trap cause encoding
//   OP_*     : supported major opcodes
//   ALUOP_*  : ALU operation class driven on ALUOp
//   SRCB_*   : ALU B-input select codes driven on ALUSrcB
package multicycle_controller_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADDR = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXEC    = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_TRAP    = 4'd10
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [3:0] ALUOP_ADD    = 4'b0000;
  localparam logic [3:0] ALUOP_BRANCH = 4'b0001;
  localparam logic [3:0] ALUOP_RTYPE  = 4'b0010;
  localparam logic [3:0] ALUOP_ITYPE  = 4'b0011;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_FOUR = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;

  // States in which the controller owns the memory port and waits on mem_ready.
  function automatic logic is_mem_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_controller_inst_legal_check.sv
// Combinational instruction classifier for the supported RV32 subset
// (lw, sw, add, sub, and, or, addi, andi, ori, beq).
// Ports:
//   inst      in  32  instruction register contents
//   is_load   out  1  lw
//   is_store  out  1  sw
//   is_rtype  out  1  add / sub / and / or
//   is_itype  out  1  addi / andi / ori
//   is_branch out  1  beq
//   illegal   out  1  none of the above
module inst_legal_check
  import multicycle_controller_pkg::*;
(
  input  logic [31:0] inst,
  output logic        is_load,
  output logic        is_store,
  output logic        is_rtype,
  output logic        is_itype,
  output logic        is_branch,
  output logic        illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = inst[6:0];
  assign funct3 = inst[14:12];
  assign funct7 = inst[31:25];

  // Register/immediate fields are irrelevant to classification.
  logic unused_fields;
  assign unused_fields = ^{inst[24:15], inst[11:7]};

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_rtype  = 1'b0;
    is_itype  = 1'b0;
    is_branch = 1'b0;
    case (opcode)
      OP_LOAD:   is_load   = (funct3 == 3'b010);
      OP_STORE:  is_store  = (funct3 == 3'b010);
      OP_RTYPE:  is_rtype  = ({funct7, funct3} == {7'b0000000, 3'b000}) ||
                             ({funct7, funct3} == {7'b0100000, 3'b000}) ||
                             ({funct7, funct3} == {7'b0000000, 3'b111}) ||
                             ({funct7, funct3} == {7'b0000000, 3'b110});
      OP_ITYPE:  is_itype  = (funct3 == 3'b000) || (funct3 == 3'b111) ||
                             (funct3 == 3'b110);
      OP_BRANCH: is_branch = (funct3 == 3'b000);
      default: ;
    endcase
    illegal = !(is_load || is_store || is_rtype || is_itype || is_branch);
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore-style controller for a multi-cycle RV32 datapath sharing one
// instruction/data memory port. Outputs decode from the state register,
// except IRWrite/PCWrite in FETCH and instret in MEMWR, which qualify on
// mem_ready so the access and its side effects land in the same cycle.
//
// Memory handshake: mem_req stays high for the whole of FETCH, MEMRD and
// MEMWR; an access completes in the cycle where mem_req and mem_ready are
// both 1. mem_ready in any other state is ignored.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   inst[31:0]                 instruction register contents
//   mem_ready                  memory completes current access
//   mem_req, IorD, MemRead, MemWrite      memory port control
//   IRWrite, PCWrite, PCWriteCond, PCSource  IR / PC update control
//   ALUSrcA, ALUSrcB[1:0], ALUOp[3:0]     ALU operand / operation select
//   RegWrite, MemtoReg                    register file writeback
//   instret                    one-cycle retire pulse
//   trap, trap_cause[1:0]      sticky fault flag and its cause
module multicycle_controller
  import multicycle_controller_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        PCSource,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [3:0]  ALUOp,
  output logic        RegWrite,
  output logic        MemtoReg,
  output logic        instret,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  localparam int CW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t         state_q, state_next;
  cause_t         cause_q, cause_next;
  logic [CW-1:0]  wait_cnt;
  logic           in_mem;
  logic           timeout_hit;

  logic is_load, is_store, is_rtype, is_itype, is_branch, illegal;

  inst_legal_check u_legal (
    .inst      (inst),
    .is_load   (is_load),
    .is_store  (is_store),
    .is_rtype  (is_rtype),
    .is_itype  (is_itype),
    .is_branch (is_branch),
    .illegal   (illegal)
  );

  assign in_mem = is_mem_state(state_q);

  // Last tolerated wait cycle without mem_ready; a ready in that same cycle
  // still completes the access. MEM_TIMEOUT == 0 turns the watchdog off.
  assign timeout_hit = (MEM_TIMEOUT != 0) && in_mem && !mem_ready &&
                       (wait_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cause_q  <= CAUSE_NONE;
      wait_cnt <= '0;
    end else begin
      state_q <= state_next;
      if ((state_next == S_TRAP) && (state_q != S_TRAP)) begin
        cause_q <= cause_next;
      end
      // Any state change clears the counter so every memory state starts
      // its own wait budget. With the watchdog off the count may wrap freely.
      if (state_next != state_q) begin
        wait_cnt <= '0;
      end else if (in_mem && !mem_ready) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
    end
  end

  always_comb begin
    state_next  = state_q;
    cause_next  = CAUSE_NONE;
    mem_req     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    PCSource    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RS2;
    ALUOp       = ALUOP_ADD;
    RegWrite    = 1'b0;
    MemtoReg    = 1'b0;
    instret     = 1'b0;

    case (state_q)
      S_IDLE: state_next = S_FETCH;

      S_FETCH: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_DECODE: begin
        // PC + imm is computed here so ALUOut holds the branch target.
        ALUSrcB = SRCB_IMM;
        if (illegal) begin
          state_next = S_TRAP;
          cause_next = CAUSE_ILLEGAL;
        end else if (is_load || is_store) begin
          state_next = S_MEMADDR;
        end else if (is_rtype || is_itype) begin
          state_next = S_EXEC;
        end else begin
          state_next = S_BRANCH;
        end
      end

      S_MEMADDR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = SRCB_IMM;
        state_next = is_load ? S_MEMRD : S_MEMWR;
      end

      S_MEMRD: begin
        mem_req = 1'b1;
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) begin
          state_next = S_MEMWB;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 1'b1;
        instret    = 1'b1;
        state_next = S_FETCH;
      end

      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          instret    = 1'b1;
          state_next = S_FETCH;
        end else if (timeout_hit) begin
          state_next = S_TRAP;
          cause_next = CAUSE_TIMEOUT;
        end
      end

      S_EXEC: begin
        ALUSrcA = 1'b1;
        if (is_itype) begin
          ALUSrcB = SRCB_IMM;
          ALUOp   = ALUOP_ITYPE;
        end else begin
          ALUSrcB = SRCB_RS2;
          ALUOp   = ALUOP_RTYPE;
        end
        state_next = S_ALUWB;
      end

      S_ALUWB: begin
        RegWrite   = 1'b1;
        instret    = 1'b1;
        state_next = S_FETCH;
      end

      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUSrcB     = SRCB_RS2;
        ALUOp       = ALUOP_BRANCH;
        PCWriteCond = 1'b1;
        PCSource    = 1'b1;
        instret     = 1'b1;
        state_next  = S_FETCH;
      end

      S_TRAP: state_next = S_TRAP;

      default: state_next = S_IDLE;
    endcase

    // Architectural side effects must never fire in a reset cycle.
    if (rst) begin
      mem_req     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      instret     = 1'b0;
    end
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller. dut1 uses the default watchdog
// (16), dut2 uses MEM_TIMEOUT=4. Inputs change on the falling edge, outputs
// are compared 1 time unit later, so each compare sees the state entered at
// the preceding rising edge plus the current mem_ready.
// Output vector bit order:
//   {mem_req,IorD,MemRead,MemWrite, IRWrite,PCWrite,PCWriteCond,PCSource,
//    ALUSrcA, ALUSrcB[1:0], ALUOp[3:0], RegWrite,MemtoReg,instret, trap,cause[1:0]}
module tb_multicycle_controller;

  localparam logic [20:0] E_ZERO      = 21'b0000_0000_0_00_0000_000_000;
  localparam logic [20:0] E_FETCH_RDY = 21'b1010_1100_0_01_0000_000_000;
  localparam logic [20:0] E_FETCH_W   = 21'b1010_0000_0_01_0000_000_000;
  localparam logic [20:0] E_DECODE    = 21'b0000_0000_0_10_0000_000_000;
  localparam logic [20:0] E_MEMADDR   = 21'b0000_0000_1_10_0000_000_000;
  localparam logic [20:0] E_MEMRD     = 21'b1110_0000_0_00_0000_000_000;
  localparam logic [20:0] E_MEMWB     = 21'b0000_0000_0_00_0000_111_000;
  localparam logic [20:0] E_MEMWR_RDY = 21'b1101_0000_0_00_0000_001_000;
  localparam logic [20:0] E_EXEC_R    = 21'b0000_0000_1_00_0010_000_000;
  localparam logic [20:0] E_EXEC_I    = 21'b0000_0000_1_10_0011_000_000;
  localparam logic [20:0] E_ALUWB     = 21'b0000_0000_0_00_0000_101_000;
  localparam logic [20:0] E_BRANCH    = 21'b0000_0011_1_00_0001_001_000;
  localparam logic [20:0] E_TRAP_ILL  = 21'b0000_0000_0_00_0000_000_101;
  localparam logic [20:0] E_TRAP_TO   = 21'b0000_0000_0_00_0000_000_110;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_ADDI = 32'h00108093;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_XOR  = 32'h0020C1B3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, rst2 = 1'b1;
  logic [31:0] inst = '0, inst2 = '0;
  logic        mem_ready = 1'b0, mem_ready2 = 1'b0;

  logic        mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource;
  logic        ALUSrcA, RegWrite, MemtoReg, instret, trap;
  logic [1:0]  ALUSrcB, trap_cause;
  logic [3:0]  ALUOp;
  logic        mem_req2, IorD2, MemRead2, MemWrite2, IRWrite2, PCWrite2, PCWriteCond2, PCSource2;
  logic        ALUSrcA2, RegWrite2, MemtoReg2, instret2, trap2;
  logic [1:0]  ALUSrcB2, trap_cause2;
  logic [3:0]  ALUOp2;

  multicycle_controller dut1 (
    .clk(clk), .rst(rst), .inst(inst), .mem_ready(mem_ready),
    .mem_req(mem_req), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .RegWrite(RegWrite),
    .MemtoReg(MemtoReg), .instret(instret), .trap(trap), .trap_cause(trap_cause)
  );

  multicycle_controller #(.MEM_TIMEOUT(4)) dut2 (
    .clk(clk), .rst(rst2), .inst(inst2), .mem_ready(mem_ready2),
    .mem_req(mem_req2), .IorD(IorD2), .MemRead(MemRead2), .MemWrite(MemWrite2),
    .IRWrite(IRWrite2), .PCWrite(PCWrite2), .PCWriteCond(PCWriteCond2), .PCSource(PCSource2),
    .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .ALUOp(ALUOp2), .RegWrite(RegWrite2),
    .MemtoReg(MemtoReg2), .instret(instret2), .trap(trap2), .trap_cause(trap_cause2)
  );

  logic [20:0] outs, outs2;
  assign outs  = {mem_req, IorD, MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, PCSource,
                  ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemtoReg, instret, trap, trap_cause};
  assign outs2 = {mem_req2, IorD2, MemRead2, MemWrite2, IRWrite2, PCWrite2, PCWriteCond2, PCSource2,
                  ALUSrcA2, ALUSrcB2, ALUOp2, RegWrite2, MemtoReg2, instret2, trap2, trap_cause2};

  int tests_run = 0;
  int tests_failed = 0;
  int instret_cnt = 0;

  // Retire pulses as seen by the datapath at each rising edge.
  always @(posedge clk) if (instret === 1'b1) instret_cnt <= instret_cnt + 1;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // Leaves the bench at the falling edge where both resets were just released.
  task automatic reset_all();
    tick(); rst = 1'b1; rst2 = 1'b1;
    tick();
    tick(); rst = 1'b0; rst2 = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    tick(); rst = 1'b1; mem_ready = 1'b1;
    tick(); #1;
    tests_run++;
    if ({mem_req, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, instret} !== 7'b0) begin
      tests_failed++;
      $display("FAIL reset_strobes got %b expected 0", {mem_req, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite, instret});
    end
    tick(); rst = 1'b0; #1;
    tests_run++;
    if (outs !== E_ZERO) begin
      tests_failed++;
      $display("FAIL reset_idle got %b expected %b", outs, E_ZERO);
    end
  endtask

  task automatic test_alu(input logic [31:0] ins, input logic [20:0] exec_exp, input string nm);
    logic [20:0] ex [5] = '{E_FETCH_RDY, E_DECODE, exec_exp, E_ALUWB, E_FETCH_RDY};
    inst = ins; mem_ready = 1'b1;
    reset_all(); #1;
    instret_cnt = 0;
    tests_run++;
    if (outs !== E_ZERO) begin
      tests_failed++;
      $display("FAIL %s_idle got %b expected %b", nm, outs, E_ZERO);
    end
    for (int i = 0; i < 5; i++) begin
      tick(); #1;
      tests_run++;
      if (outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL %s step %0d got %b expected %b", nm, i, outs, ex[i]);
      end
    end
    tests_run++;
    if (instret_cnt !== 1) begin
      tests_failed++;
      $display("FAIL %s_instret got %0d expected 1", nm, instret_cnt);
    end
  endtask

  task automatic test_lw_wait();
    logic [20:0] ex [9] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMRD, E_MEMRD, E_MEMRD,
                           E_MEMRD, E_MEMWB, E_FETCH_RDY};
    logic rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    inst = I_LW; mem_ready = 1'b1;
    reset_all();
    instret_cnt = 0;
    for (int i = 0; i < 9; i++) begin
      tick(); mem_ready = rdy[i]; #1;
      tests_run++;
      if (outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL lw_wait step %0d got %b expected %b", i, outs, ex[i]);
      end
    end
    tests_run++;
    if (instret_cnt !== 1) begin
      tests_failed++;
      $display("FAIL lw_instret got %0d expected 1", instret_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [20:0] ex [8] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR, E_MEMWR_RDY, E_FETCH_RDY,
                           E_DECODE, E_BRANCH, E_FETCH_RDY};
    inst = I_SW; mem_ready = 1'b1;
    reset_all();
    instret_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 4) inst = I_BEQ;  // IR loads the branch at the end of this fetch
      #1;
      tests_run++;
      if (outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL sw_beq step %0d got %b expected %b", i, outs, ex[i]);
      end
    end
    tests_run++;
    if (instret_cnt !== 2) begin
      tests_failed++;
      $display("FAIL sw_beq_instret got %0d expected 2", instret_cnt);
    end
  endtask

  task automatic test_illegal();
    inst = I_XOR; mem_ready = 1'b1;
    reset_all();
    tick(); #1;
    tests_run++;
    if (outs !== E_FETCH_RDY) begin
      tests_failed++;
      $display("FAIL illegal_fetch got %b expected %b", outs, E_FETCH_RDY);
    end
    tick(); #1;
    tests_run++;
    if (outs !== E_DECODE) begin
      tests_failed++;
      $display("FAIL illegal_decode got %b expected %b", outs, E_DECODE);
    end
    for (int i = 0; i < 20; i++) begin
      tick(); mem_ready = 1'($urandom_range(0, 1)); #1;
      tests_run++;
      if (outs !== E_TRAP_ILL) begin
        tests_failed++;
        $display("FAIL illegal_trap cycle %0d got %b expected %b", i, outs, E_TRAP_ILL);
      end
    end
    tick(); rst = 1'b1; #1;
    tests_run++;
    if ({mem_req, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite} !== 6'b0) begin
      tests_failed++;
      $display("FAIL illegal_rst_strobes got %b expected 0", {mem_req, IRWrite, PCWrite, PCWriteCond, RegWrite, MemWrite});
    end
    tick(); rst = 1'b0; #1;
    tests_run++;
    if (outs !== E_ZERO) begin
      tests_failed++;
      $display("FAIL illegal_rst_idle got %b expected %b", outs, E_ZERO);
    end
  endtask

  task automatic test_timeout_fetch();
    logic [20:0] ex [7] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_W, E_TRAP_TO, E_TRAP_TO, E_TRAP_TO};
    logic rdy [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    inst2 = I_ADD; mem_ready2 = 1'b0;
    reset_all();
    for (int i = 0; i < 7; i++) begin
      tick(); mem_ready2 = rdy[i]; #1;
      tests_run++;
      if (outs2 !== ex[i]) begin
        tests_failed++;
        $display("FAIL timeout_fetch step %0d got %b expected %b", i, outs2, ex[i]);
      end
    end
  endtask

  task automatic test_timeout_ready_wins();
    logic [20:0] ex [6] = '{E_FETCH_W, E_FETCH_W, E_FETCH_W, E_FETCH_RDY, E_DECODE, E_EXEC_R};
    logic rdy [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    inst2 = I_ADD; mem_ready2 = 1'b0;
    reset_all();
    for (int i = 0; i < 6; i++) begin
      tick(); mem_ready2 = rdy[i]; #1;
      tests_run++;
      if (outs2 !== ex[i]) begin
        tests_failed++;
        $display("FAIL timeout_ready step %0d got %b expected %b", i, outs2, ex[i]);
      end
    end
  endtask

  // Two fetch wait cycles must not count against the later MEMRD budget.
  task automatic test_timeout_memrd();
    logic [20:0] ex [10] = '{E_FETCH_W, E_FETCH_W, E_FETCH_RDY, E_DECODE, E_MEMADDR,
                            E_MEMRD, E_MEMRD, E_MEMRD, E_MEMRD, E_TRAP_TO};
    logic rdy [10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    inst2 = I_LW; mem_ready2 = 1'b0;
    reset_all();
    for (int i = 0; i < 10; i++) begin
      tick(); mem_ready2 = rdy[i]; #1;
      tests_run++;
      if (outs2 !== ex[i]) begin
        tests_failed++;
        $display("FAIL timeout_memrd step %0d got %b expected %b", i, outs2, ex[i]);
      end
    end
  endtask

  task automatic test_reset_in_memwr();
    logic [20:0] ex [3] = '{E_FETCH_RDY, E_DECODE, E_MEMADDR};
    inst = I_SW; mem_ready = 1'b1;
    reset_all();
    instret_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      tests_run++;
      if (outs !== ex[i]) begin
        tests_failed++;
        $display("FAIL rst_memwr step %0d got %b expected %b", i, outs, ex[i]);
      end
    end
    tick(); rst = 1'b1; mem_ready = 1'b1; #1;
    tests_run++;
    if ({MemWrite, mem_req, instret} !== 3'b000) begin
      tests_failed++;
      $display("FAIL rst_memwr_strobes got %b expected 000", {MemWrite, mem_req, instret});
    end
    tick(); rst = 1'b0; #1;
    tests_run++;
    if (outs !== E_ZERO) begin
      tests_failed++;
      $display("FAIL rst_memwr_idle got %b expected %b", outs, E_ZERO);
    end
    tick(); #1;
    tests_run++;
    if (outs !== E_FETCH_RDY) begin
      tests_failed++;
      $display("FAIL rst_memwr_refetch got %b expected %b", outs, E_FETCH_RDY);
    end
    tests_run++;
    if (instret_cnt !== 0) begin
      tests_failed++;
      $display("FAIL rst_memwr_instret got %0d expected 0", instret_cnt);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_alu(I_ADD, E_EXEC_R, "add");
    test_alu(I_ADDI, E_EXEC_I, "addi");
    test_lw_wait();
    test_back_to_back();
    test_illegal();
    test_timeout_fetch();
    test_timeout_ready_wins();
    test_timeout_memrd();
    test_reset_in_memwr();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
